// File: rtl/key_controls.sv
// Keyboard-to-game control decoder: tracks seven held keys from a PS/2-style
// make/break stream and produces throttle levels, shift ticks and a start pulse.
module key_controls #(
  parameter logic [7:0] P1_GAS = 8'h1D,
  parameter logic [7:0] P1_UP  = 8'h23,
  parameter logic [7:0] P1_DN  = 8'h1C,
  parameter logic [7:0] P2_GAS = 8'h43,
  parameter logic [7:0] P2_UP  = 8'h4B,
  parameter logic [7:0] P2_DN  = 8'h3B,
  parameter logic [7:0] START  = 8'h29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_new,
  input  logic       key_pressed,
  input  logic [7:0] key_code,
  output logic       p1_gas,
  output logic       p1_up_tick,
  output logic       p1_dn_tick,
  output logic       p2_gas,
  output logic       p2_up_tick,
  output logic       p2_dn_tick,
  output logic       start_tick,
  output logic       ready
);

  localparam int K_P1GAS = 0;
  localparam int K_P1UP  = 1;
  localparam int K_P1DN  = 2;
  localparam int K_P2GAS = 3;
  localparam int K_P2UP  = 4;
  localparam int K_P2DN  = 5;
  localparam int K_START = 6;

  typedef enum logic [1:0] {IDLE, ARMED, FIRED} start_state_t;

  start_state_t start_state;
  logic [6:0]   flags;
  logic [6:0]   flags_next;
  logic [6:0]   key_hit;
  logic [6:0]   fresh;
  logic         key_pressed_d;
  logic [7:0]   key_code_d;
  logic         release_evt;

  // A break is seen either as key_pressed falling, or as a new code arriving
  // while key_pressed is already low (a second key released in a row).
  always_comb begin
    key_hit          = '0;
    key_hit[K_P1GAS] = (key_code == P1_GAS);
    key_hit[K_P1UP]  = (key_code == P1_UP);
    key_hit[K_P1DN]  = (key_code == P1_DN);
    key_hit[K_P2GAS] = (key_code == P2_GAS);
    key_hit[K_P2UP]  = (key_code == P2_UP);
    key_hit[K_P2DN]  = (key_code == P2_DN);
    key_hit[K_START] = (key_code == START);

    release_evt = ~key_pressed & (key_pressed_d | (key_code != key_code_d));

    // Make has priority over a simultaneous release of the same key.
    flags_next = flags;
    for (int i = 0; i < 7; i++) begin
      if (key_hit[i] && code_new)
        flags_next[i] = 1'b1;
      else if (key_hit[i] && release_evt)
        flags_next[i] = 1'b0;
    end

    fresh = {7{code_new}} & key_hit & ~flags;
  end

  assign p1_gas = flags[K_P1GAS];
  assign p2_gas = flags[K_P2GAS];

  // ready is taken from the next flag values so it changes in the same
  // cycle as the gas levels it is derived from.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags         <= '0;
      key_pressed_d <= 1'b0;
      key_code_d    <= 8'h00;
      p1_up_tick    <= 1'b0;
      p1_dn_tick    <= 1'b0;
      p2_up_tick    <= 1'b0;
      p2_dn_tick    <= 1'b0;
      ready         <= 1'b0;
      start_tick    <= 1'b0;
      start_state   <= IDLE;
    end else begin
      flags         <= flags_next;
      key_pressed_d <= key_pressed;
      key_code_d    <= key_code;
      p1_up_tick    <= fresh[K_P1UP];
      p1_dn_tick    <= fresh[K_P1DN];
      p2_up_tick    <= fresh[K_P2UP];
      p2_dn_tick    <= fresh[K_P2DN];
      ready         <= ~flags_next[K_P1GAS] & ~flags_next[K_P2GAS];
      start_tick    <= 1'b0;

      case (start_state)
        IDLE: begin
          if (ready)
            start_state <= ARMED;
        end
        ARMED: begin
          if (fresh[K_START] && ready) begin
            start_state <= FIRED;
            start_tick  <= 1'b1;
          end else if (!ready) begin
            start_state <= IDLE;
          end
        end
        FIRED: begin
          if (!flags[K_START])
            start_state <= IDLE;
        end
        default: start_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_controls.sv
// Scoreboard bench for key_controls: expected output vectors are queued as
// stimulus is driven and compared against sampled outputs after each edge.
module tb_key_controls;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       code_new = 1'b0;
  logic       key_pressed = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       p1_gas, p1_up_tick, p1_dn_tick;
  logic       p2_gas, p2_up_tick, p2_dn_tick;
  logic       start_tick, ready;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  string      name_q[$];

  // Vector order: {p1_gas, p1_up, p1_dn, p2_gas, p2_up, p2_dn, start_tick, ready}
  localparam logic [7:0] NONE  = 8'h00;
  localparam logic [7:0] RDY   = 8'h01;
  localparam logic [7:0] START = 8'h03;
  localparam logic [7:0] P1G   = 8'h80;
  localparam logic [7:0] P1U   = 8'h41;
  localparam logic [7:0] P1D   = 8'h21;
  localparam logic [7:0] P2G   = 8'h10;
  localparam logic [7:0] P2U   = 8'h09;
  localparam logic [7:0] P2D   = 8'h05;
  localparam logic [7:0] BOTHG = 8'h90;

  key_controls dut (
    .clk        (clk),
    .reset      (reset),
    .code_new   (code_new),
    .key_pressed(key_pressed),
    .key_code   (key_code),
    .p1_gas     (p1_gas),
    .p1_up_tick (p1_up_tick),
    .p1_dn_tick (p1_dn_tick),
    .p2_gas     (p2_gas),
    .p2_up_tick (p2_up_tick),
    .p2_dn_tick (p2_dn_tick),
    .start_tick (start_tick),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rs, input logic cn, input logic kp,
                      input logic [7:0] kc, input logic [7:0] expv,
                      input string nm);
    reset       = rs;
    code_new    = cn;
    key_pressed = kp;
    key_code    = kc;
    exp_q.push_back(expv);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    obs_q.push_back({p1_gas, p1_up_tick, p1_dn_tick, p2_gas, p2_up_tick,
                     p2_dn_tick, start_tick, ready});
    code_new = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] e, o;
    string n;
    step(1, 0, 0, 8'h00, NONE, "reset_a");
    step(1, 1, 1, 8'h1D, NONE, "reset_b");
    step(0, 0, 0, 8'h00, RDY,  "post_reset_1");
    step(0, 0, 0, 8'h00, RDY,  "post_reset_2");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_start();
    logic [7:0] e, o;
    string n;
    step(0, 1, 1, 8'h29, START, "start_first");
    step(0, 0, 1, 8'h29, RDY,   "start_pulse_end");
    step(0, 1, 1, 8'h29, RDY,   "start_repeat");
    step(0, 0, 1, 8'h29, RDY,   "start_hold");
    step(0, 0, 0, 8'h29, RDY,   "start_release");
    step(0, 0, 0, 8'h29, RDY,   "start_idle_1");
    step(0, 0, 0, 8'h29, RDY,   "start_idle_2");
    step(0, 1, 1, 8'h29, START, "start_again");
    step(0, 0, 1, 8'h29, RDY,   "start_again_end");
    step(0, 0, 0, 8'h29, RDY,   "start_release_2");
    step(0, 0, 0, 8'h29, RDY,   "start_idle_3");
    step(0, 0, 0, 8'h29, RDY,   "start_idle_4");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_typematic();
    logic [7:0] e, o;
    string n;
    step(0, 1, 1, 8'h23, P1U, "up_first");
    step(0, 1, 1, 8'h23, RDY, "up_repeat_1");
    step(0, 1, 1, 8'h23, RDY, "up_repeat_2");
    step(0, 0, 0, 8'h23, RDY, "up_release");
    step(0, 1, 1, 8'h1C, P1D, "dn_p1");
    step(0, 0, 0, 8'h1C, RDY, "dn_p1_release");
    step(0, 1, 1, 8'h4B, P2U, "up_p2_b2b");
    step(0, 1, 1, 8'h3B, P2D, "dn_p2_b2b");
    step(0, 0, 0, 8'h3B, RDY, "dn_p2_release");
    step(0, 0, 0, 8'h4B, RDY, "up_p2_release");
    step(0, 1, 1, 8'h4B, P2U, "up_p2_fresh_again");
    step(0, 0, 0, 8'h4B, RDY, "up_p2_release_2");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_gas();
    logic [7:0] e, o;
    string n;
    step(0, 1, 1, 8'h1D, P1G,   "gas_p1_press");
    step(0, 1, 1, 8'h43, BOTHG, "gas_p2_press");
    step(0, 0, 0, 8'h1D, P2G,   "gas_p1_release");
    step(0, 0, 0, 8'h43, RDY,   "gas_p2_release");
    step(0, 0, 0, 8'h43, RDY,   "gas_idle_1");
    step(0, 0, 0, 8'h43, RDY,   "gas_idle_2");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_start_blocked();
    logic [7:0] e, o;
    string n;
    step(0, 1, 1, 8'h1D, P1G,   "blk_gas_press");
    step(0, 0, 1, 8'h1D, P1G,   "blk_gas_hold");
    step(0, 1, 1, 8'h29, P1G,   "blk_start_ignored");
    step(0, 0, 0, 8'h1D, RDY,   "blk_gas_release");
    step(0, 0, 0, 8'h29, RDY,   "blk_start_release");
    step(0, 1, 1, 8'h29, START, "blk_start_fresh");
    step(0, 0, 1, 8'h29, RDY,   "blk_start_end");
    step(0, 0, 0, 8'h29, RDY,   "blk_release");
    step(0, 0, 0, 8'h29, RDY,   "blk_idle_1");
    step(0, 0, 0, 8'h29, RDY,   "blk_idle_2");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_make_wins();
    logic [7:0] e, o;
    string n;
    step(0, 1, 1, 8'h1C, P1D, "mw_setup");
    step(0, 1, 0, 8'h43, P2G, "mw_make_and_release");
    step(0, 0, 0, 8'h1C, P2G, "mw_release_other");
    step(0, 0, 0, 8'h43, RDY, "mw_release_gas");
    step(0, 0, 0, 8'h43, RDY, "mw_idle_1");
    step(0, 0, 0, 8'h43, RDY, "mw_idle_2");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_unmapped();
    logic [7:0] e, o;
    string n;
    step(0, 1, 1, 8'h1D, P1G, "um_gas_press");
    step(0, 1, 1, 8'h5A, P1G, "um_make_5a");
    step(0, 1, 1, 8'hE0, P1G, "um_make_e0");
    step(0, 1, 1, 8'hF0, P1G, "um_make_f0");
    step(0, 0, 0, 8'h5A, P1G, "um_release_5a");
    step(0, 0, 0, 8'h1D, RDY, "um_gas_release");
    step(0, 0, 0, 8'h1D, RDY, "um_idle_1");
    step(0, 0, 0, 8'h1D, RDY, "um_idle_2");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", n, o, e);
      end
    end
  endtask

  task automatic test_reset_midpress();
    logic [7:0] e, o;
    string n;
    step(0, 1, 1, 8'h43, P2G,   "rm_gas_press");
    step(0, 1, 1, 8'h4B, 8'h18, "rm_up_press");
    step(1, 0, 1, 8'h4B, NONE,  "rm_reset");
    step(0, 0, 1, 8'h4B, RDY,   "rm_after_reset");
    step(0, 1, 1, 8'h4B, P2U,   "rm_typematic_fresh");
    step(0, 0, 0, 8'h4B, RDY,   "rm_release");
    step(0, 0, 0, 8'h4B, RDY,   "rm_idle");
    step(0, 1, 1, 8'h29, START, "rm_start_after_reset");
    step(0, 0, 0, 8'h29, RDY,   "rm_start_release");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", n, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_typematic();
    test_gas();
    test_start_blocked();
    test_make_wins();
    test_unmapped();
    test_reset_midpress();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_controls.md
KEY_CONTROLS -- requirements
Module: key_controls

Interface
REQ-001 Parameters (name, default, meaning):
- P1_GAS, 8'h1D, scan code of player 1 throttle (W).
- P1_UP, 8'h23, player 1 shift-up (D).
- P1_DN, 8'h1C, player 1 shift-down (A).
- P2_GAS, 8'h43, player 2 throttle (I).
- P2_UP, 8'h4B, player 2 shift-up (L).
- P2_DN, 8'h3B, player 2 shift-down (J).
- START, 8'h29, race start (Space).
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, system clock; one clock domain only.
- reset, in, 1, synchronous, active-high.
- code_new, in, 1, one-cycle pulse: make code present on key_code.
- key_pressed, in, 1, level: 1 after a make code, 0 after a break code.
- key_code, in, 8, last make or break scan code.
- p1_gas, out, 1, level: player 1 throttle key held.
- p1_up_tick, out, 1, one-cycle pulse per fresh shift-up press.
- p1_dn_tick, out, 1, one-cycle pulse per fresh shift-down press.
- p2_gas, out, 1, level: player 2 throttle key held.
- p2_up_tick, out, 1, one-cycle pulse per fresh shift-up press.
- p2_dn_tick, out, 1, one-cycle pulse per fresh shift-down press.
- start_tick, out, 1, one-cycle pulse: start accepted.
- ready, out, 1, level: both throttles released, start allowed.

Function
REQ-003 Seven per-key held flags (one per parameter code); all outputs registered.
REQ-004 Make event: code_new==1 in the cycle; the matching key's flag is set in the next cycle.
REQ-005 Release event: key_pressed==0 and (key_pressed_d==1 or key_code!=key_code_d). key_pressed_d and key_code_d are one-cycle registered copies. The matching key's flag is cleared in the next cycle.
REQ-006 Unmapped codes (including 8'hE0 and 8'hF0) are ignored; no flag or output changes.
REQ-007 Fresh press: a make event on a key whose flag is 0. Typematic repeats (make event with flag already 1) produce no tick.
REQ-008 p1_up_tick, p1_dn_tick, p2_up_tick, p2_dn_tick are high for exactly the one cycle after a fresh press of their key.
REQ-009 p1_gas and p2_gas equal the P1_GAS and P2_GAS flags; latency 1 cycle from the event.
REQ-010 ready = ~P1_GAS flag & ~P2_GAS flag, registered.
REQ-011 Start FSM, states IDLE, ARMED, FIRED:
- IDLE->ARMED when ready==1.
- ARMED->FIRED on a fresh START press while ready==1; start_tick pulses in the cycle FIRED is entered.
- ARMED->IDLE if ready drops.
- FIRED->IDLE when the START flag clears.
REQ-012 A START press in IDLE, or a repeated START make in ARMED, produces no start_tick.
REQ-013 Make and release events for the same key in the same cycle: the make wins (flag set, tick allowed).
REQ-014 Events for different keys in consecutive cycles are each processed; none are lost.
REQ-015 At most one input event per cycle. Multiple output ticks in the same cycle are impossible by construction and are not required.

Reset
REQ-016 While reset==1 at a clk edge: all flags clear, all outputs 0, key_pressed_d=0, key_code_d=8'h00, FSM=IDLE.
REQ-017 Reset mid-press clears held state. A key still physically held re-registers only on its next typematic make, which counts as a fresh press.
REQ-018 First event is accepted in the cycle after reset deasserts.

Verification
REQ-019 Pulse code_new with key_code=8'h23 three times (typematic) -> p1_up_tick exactly once, one cycle after the first pulse.
REQ-020 Press 8'h1D, press 8'h43, then release 8'h1D, then release 8'h43 (the second release has key_pressed already 0, code changes) -> p1_gas and p2_gas each fall 1 cycle after their own release.
REQ-021 After reset, wait 2 cycles, then make 8'h29 -> start_tick one pulse; repeat make 8'h29 -> no pulse; release, then make again -> one pulse.
REQ-022 Hold 8'h1D, then make 8'h29 -> no start_tick, ready=0; release 8'h1D, then fresh 8'h29 -> start_tick.
REQ-023 Make 8'h5A (unmapped) -> all outputs unchanged.
REQ-024 Assert reset while p2_gas=1 -> next cycle all outputs 0, FSM IDLE.
